// File: rtl/i2c_reg_pkg.sv
// i2c_reg_pkg: shared types and constants for the I2C register controller
package i2c_reg_pkg;
   localparam int BYTE_W = 8;
   typedef enum logic [1:0] {IDLE, PTR, WRITE, READ} state_t;
endpackage

// File: rtl/i2c_reg_ctrl_sync_edge.sv
// sync_edge: multi-flop synchronizer with rising-edge pulse output
//   clk   in  system clock
//   rstb  in  synchronous reset, active-low
//   d     in  asynchronous level
//   rise  out one-cycle pulse on a synchronized 0->1 transition
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstb,
   input  logic d,
   output logic rise
);
   logic [STAGES-1:0] sh;
   logic              q_d;
   always_ff @(posedge clk) begin
      if (!rstb) begin
         sh  <= '0;
         q_d <= 1'b0;
      end else begin
         sh  <= {sh[STAGES-2:0], d};
         q_d <= sh[STAGES-1];
      end
   end
   assign rise = sh[STAGES-1] & ~q_d;
endmodule

// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: register-file controller driven by the i2c_slave byte interface
//   clk, rstb     system clock, synchronous active-low reset
//   i2c_data_out  byte received by the slave
//   i2c_data_vld  byte-complete level
//   i2c_r_w       transaction direction, 1 = master reads
//   i2c_start     start / repeated-start level
//   i2c_stop      stop level
//   i2c_data_in   byte for the slave to transmit
//   i2c_ready     i2c_data_in valid during a read
//   regs_out      register file, reg n at [8n+7:8n]
//   wr_strobe     one-cycle pulse per register write
//   wr_addr       address written, valid with wr_strobe
module i2c_reg_ctrl
   import i2c_reg_pkg::*;
#(
   parameter int          NUM_REGS    = 8,
   parameter logic [7:0]  RESET_VAL   = 8'h00,
   parameter int          SYNC_STAGES = 2,
   localparam int         ADDR_W      = $clog2(NUM_REGS)
) (
   input  logic                       clk,
   input  logic                       rstb,
   input  logic [7:0]                 i2c_data_out,
   input  logic                       i2c_data_vld,
   input  logic                       i2c_r_w,
   input  logic                       i2c_start,
   input  logic                       i2c_stop,
   output logic [7:0]                 i2c_data_in,
   output logic                       i2c_ready,
   output logic [NUM_REGS*8-1:0]      regs_out,
   output logic                       wr_strobe,
   output logic [ADDR_W-1:0]          wr_addr
);
   state_t                                  state, state_nxt;
   logic [ADDR_W-1:0]                       ptr, ptr_nxt;
   logic [NUM_REGS-1:0][BYTE_W-1:0]         regs;
   logic [SYNC_STAGES-1:0][BYTE_W:0]        dsync;
   logic [BYTE_W-1:0]                       rx_byte;
   logic                                    rw_s, evt_vld, evt_start, evt_stop, we, ready_nxt;

   sync_edge #(.STAGES(SYNC_STAGES)) u_vld   (.clk(clk), .rstb(rstb), .d(i2c_data_vld), .rise(evt_vld));
   sync_edge #(.STAGES(SYNC_STAGES)) u_start (.clk(clk), .rstb(rstb), .d(i2c_start),    .rise(evt_start));
   sync_edge #(.STAGES(SYNC_STAGES)) u_stop  (.clk(clk), .rstb(rstb), .d(i2c_stop),     .rise(evt_stop));

   // r_w and data share one chain so they line up with the event pulses
   assign rx_byte  = dsync[SYNC_STAGES-1][BYTE_W-1:0];
   assign rw_s     = dsync[SYNC_STAGES-1][BYTE_W];
   assign regs_out = regs;

   always_ff @(posedge clk) begin
      if (!rstb) state <= IDLE;
      else       state <= state_nxt;
   end

   // start outranks stop and any coincident byte; a byte coincident with stop is still processed
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      ready_nxt = i2c_ready;
      we        = 1'b0;
      if (evt_start) begin
         state_nxt = rw_s ? READ : PTR;
         ready_nxt = rw_s;
      end else begin
         if (evt_vld && state == PTR) begin
            ptr_nxt   = rx_byte[ADDR_W-1:0];
            state_nxt = WRITE;
         end
         if (evt_vld && (state == WRITE || state == READ)) ptr_nxt = ptr + ADDR_W'(1);
         we = evt_vld && state == WRITE;
         if (evt_stop) begin
            state_nxt = IDLE;
            ready_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         ptr         <= '0;
         regs        <= {NUM_REGS{RESET_VAL}};
         i2c_data_in <= '0;
         i2c_ready   <= 1'b0;
         wr_strobe   <= 1'b0;
         wr_addr     <= '0;
         dsync       <= '0;
      end else begin
         dsync     <= {dsync[SYNC_STAGES-2:0], {i2c_r_w, i2c_data_out}};
         ptr       <= ptr_nxt;
         i2c_ready <= ready_nxt;
         wr_strobe <= we;
         if (we) begin
            regs[ptr] <= rx_byte;
            wr_addr   <= ptr;
         end
         if (state_nxt == READ) i2c_data_in <= regs[ptr_nxt];
      end
   end
endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb_i2c_reg_ctrl: directed scoreboard bench for i2c_reg_ctrl
module tb_i2c_reg_ctrl;
   typedef struct {logic [2:0] addr; logic [7:0] data;} wr_t;

   logic        clk = 1'b0;
   logic        rstb;
   logic [7:0]  i2c_data_out;
   logic        i2c_data_vld, i2c_r_w, i2c_start, i2c_stop;
   logic [7:0]  i2c_data_in;
   logic        i2c_ready;
   logic [63:0] regs_out;
   logic        wr_strobe;
   logic [2:0]  wr_addr;

   int          checks = 0;
   int          errors = 0;
   int          strobes = 0;
   wr_t         sb[$];
   logic [7:0]  mregs[8];
   logic [2:0]  mptr;

   i2c_reg_ctrl #(.NUM_REGS(8), .RESET_VAL(8'hA5), .SYNC_STAGES(2)) dut (
      .clk(clk), .rstb(rstb), .i2c_data_out(i2c_data_out), .i2c_data_vld(i2c_data_vld),
      .i2c_r_w(i2c_r_w), .i2c_start(i2c_start), .i2c_stop(i2c_stop),
      .i2c_data_in(i2c_data_in), .i2c_ready(i2c_ready), .regs_out(regs_out),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      wr_t e;
      #1;
      if (wr_strobe === 1'b1) begin
         strobes++;
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_strobe addr %0d data %h want no strobe", wr_addr, regs_out[8*wr_addr +: 8]);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (wr_addr === e.addr && regs_out[8*e.addr +: 8] === e.data) else begin
               errors++;
               $error("FAIL strobe got addr %0d data %h want addr %0d data %h",
                      wr_addr, regs_out[8*wr_addr +: 8], e.addr, e.data);
            end
         end
      end
   end

   function automatic logic [63:0] model_vec();
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[8*i +: 8] = mregs[i];
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mregs[i] = 8'hA5;
      mptr = 3'd0;
   endtask

   task automatic pulse(input logic [7:0] b);
      @(negedge clk);
      i2c_data_out = b;
      i2c_data_vld = 1'b1;
      repeat (3) @(negedge clk);
      i2c_data_vld = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic ptr_byte(input logic [7:0] b);
      mptr = b[2:0];
      pulse(b);
   endtask

   task automatic wr_byte(input logic [7:0] b);
      sb.push_back('{addr: mptr, data: b});
      mregs[mptr] = b;
      mptr = mptr + 3'd1;
      pulse(b);
   endtask

   task automatic rd_byte();
      mptr = mptr + 3'd1;
      pulse(8'h00);
   endtask

   task automatic do_start(input logic rw);
      @(negedge clk);
      i2c_r_w   = rw;
      i2c_start = 1'b1;
      repeat (3) @(negedge clk);
      i2c_start = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_stop();
      @(negedge clk);
      i2c_stop = 1'b1;
      repeat (3) @(negedge clk);
      i2c_stop = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int s0;
      rstb = 1'b0;
      i2c_data_out = 8'h00;
      i2c_data_vld = 1'b0;
      i2c_r_w = 1'b0;
      i2c_start = 1'b0;
      i2c_stop = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_regs", regs_out, model_vec());
      chk("reset_ready", 64'(i2c_ready), 64'd0);
      chk("reset_strobe", 64'(wr_strobe), 64'd0);
      chk("reset_data_in", 64'(i2c_data_in), 64'd0);
      rstb = 1'b1;
      repeat (2) @(negedge clk);

      do_start(1'b0);
      ptr_byte(8'h02);
      wr_byte(8'h11);
      wr_byte(8'h22);
      do_stop();
      chk("write_regs", regs_out, model_vec());
      chk("write_strobes", 64'(strobes), 64'd2);

      do_start(1'b0);
      ptr_byte(8'h07);
      wr_byte(8'hAA);
      wr_byte(8'hBB);
      do_stop();
      chk("wrap_regs", regs_out, model_vec());
      do_start(1'b0);
      ptr_byte(8'h0F);
      do_stop();
      do_start(1'b1);
      chk("ptr_upper_ignored", 64'(i2c_data_in), 64'(mregs[7]));
      chk("read_ready", 64'(i2c_ready), 64'd1);
      do_stop();
      chk("stop_ready", 64'(i2c_ready), 64'd0);

      do_start(1'b0);
      ptr_byte(8'h03);
      do_start(1'b1);
      chk("restart_data", 64'(i2c_data_in), 64'(mregs[3]));
      chk("restart_ready", 64'(i2c_ready), 64'd1);
      rd_byte();
      chk("read_advance", 64'(i2c_data_in), 64'(mregs[mptr]));
      chk("read_ready_held", 64'(i2c_ready), 64'd1);
      do_stop();
      chk("read_stop_ready", 64'(i2c_ready), 64'd0);
      chk("read_no_write", regs_out, model_vec());

      do_start(1'b0);
      ptr_byte(8'h05);
      sb.push_back('{addr: 3'd5, data: 8'h5C});
      mregs[5] = 8'h5C;
      @(negedge clk);
      i2c_data_out = 8'h5C;
      i2c_data_vld = 1'b1;
      i2c_stop = 1'b1;
      repeat (3) @(negedge clk);
      i2c_data_vld = 1'b0;
      i2c_stop = 1'b0;
      repeat (3) @(negedge clk);
      chk("vld_stop_regs", regs_out, model_vec());
      s0 = strobes;
      pulse(8'h77);
      chk("idle_vld_ignored", regs_out, model_vec());
      chk("idle_no_strobe", 64'(strobes), 64'(s0));

      do_start(1'b0);
      ptr_byte(8'h01);
      s0 = strobes;
      @(negedge clk);
      i2c_data_out = 8'h99;
      i2c_data_vld = 1'b1;
      repeat (2) @(negedge clk);
      rstb = 1'b0;
      i2c_data_vld = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      repeat (4) @(negedge clk);
      chk("midreset_regs", regs_out, model_vec());
      chk("midreset_no_strobe", 64'(strobes), 64'(s0));
      chk("midreset_ready", 64'(i2c_ready), 64'd0);
      do_start(1'b0);
      ptr_byte(8'h06);
      wr_byte(8'h3C);
      do_stop();
      chk("post_reset_write", regs_out, model_vec());
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
